jk_register_bank: RTL and testbench



---
 rtl/jk_bank_pkg.sv | 11 +
 rtl/jk_register_bank_if.sv | 53 +++++
 rtl/jk_register_bank_bit_cell.sv | 54 +++++
 rtl/jk_register_bank.sv | 75 +++++++
 tb/tb_jk_register_bank.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/jk_bank_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_ROL  = 2'b11
  } mode_e;

endpackage : jk_bank_pkg

// File: rtl/jk_register_bank_if.sv
// Control/data bundle for jk_register_bank.
// JK_CHANGE_COUNT_EN adds change_count and its COUNT_WIDTH parameter.
interface jk_register_bank_if
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef JK_CHANGE_COUNT_EN
  ,
  parameter int COUNT_WIDTH = 16
`endif
);

  logic             enable;
  mode_e            mode;
  logic [WIDTH-1:0] signal_J;
  logic [WIDTH-1:0] signal_K;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] preset_mask;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] signal_out_neg;
  logic             serial_out;
  logic             changed;
`ifdef JK_CHANGE_COUNT_EN
  logic [COUNT_WIDTH-1:0] change_count;

  modport master (
    output enable, mode, signal_J, signal_K, data_in, serial_in,
           clear_mask, preset_mask,
    input  signal_out, signal_out_neg, serial_out, changed, change_count
  );

  modport slave (
    input  enable, mode, signal_J, signal_K, data_in, serial_in,
           clear_mask, preset_mask,
    output signal_out, signal_out_neg, serial_out, changed, change_count
  );
`else
  modport master (
    output enable, mode, signal_J, signal_K, data_in, serial_in,
           clear_mask, preset_mask,
    input  signal_out, signal_out_neg, serial_out, changed
  );

  modport slave (
    input  enable, mode, signal_J, signal_K, data_in, serial_in,
           clear_mask, preset_mask,
    output signal_out, signal_out_neg, serial_out, changed
  );
`endif

endinterface : jk_register_bank_if

// File: rtl/jk_register_bank_bit_cell.sv
// Next-state logic for one bank bit: mode result, then clear/preset priority.
module jk_bit_cell
  import jk_bank_pkg::*;
(
  input  logic  i_q,
  input  logic  i_j,
  input  logic  i_k,
  input  logic  i_load_d,
  input  logic  i_shl_d,
  input  logic  i_rol_d,
  input  logic  i_enable,
  input  logic  i_clear,
  input  logic  i_preset,
  input  mode_e i_mode,
  output logic  o_d
);

  logic w_jk;
  logic w_mode_d;

  always_comb begin
    w_jk = i_q;
    unique case ({i_j, i_k})
      2'b00:   w_jk = i_q;
      2'b01:   w_jk = 1'b0;
      2'b10:   w_jk = 1'b1;
      default: w_jk = ~i_q;
    endcase
  end

  always_comb begin
    w_mode_d = i_q;
    unique case (i_mode)
      MODE_JK:   w_mode_d = w_jk;
      MODE_LOAD: w_mode_d = i_load_d;
      MODE_SHL:  w_mode_d = i_shl_d;
      MODE_ROL:  w_mode_d = i_rol_d;
      default:   w_mode_d = i_q;
    endcase
  end

  // Masks act regardless of enable; clear wins over preset.
  always_comb begin
    o_d = i_q;
    if (i_clear) begin
      o_d = 1'b0;
    end else if (i_preset) begin
      o_d = 1'b1;
    end else if (i_enable) begin
      o_d = w_mode_d;
    end
  end

endmodule : jk_bit_cell

// File: rtl/jk_register_bank.sv
// WIDTH-bit JK register bank with load/shift/rotate modes and change flag.
// JK_CHANGE_COUNT_EN adds a saturating change counter on the interface.
module jk_register_bank
  import jk_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               COUNT_WIDTH = 16
) (
  input logic               clock_pos,
  input logic               reset_pos,
  jk_register_bank_if.slave bus
);

  if (WIDTH < 2 || COUNT_WIDTH < 1) begin : g_param_check
    $error("jk_register_bank: WIDTH must be >= 2 and COUNT_WIDTH >= 1");
  end

  logic [WIDTH-1:0] r_state;
  logic             r_changed;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_rol;
  logic             w_diff;

  assign w_shl  = {r_state[WIDTH-2:0], bus.serial_in};
  assign w_rol  = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
  assign w_diff = (w_next != r_state);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_bit_cell u_cell (
      .i_q      (r_state[i]),
      .i_j      (bus.signal_J[i]),
      .i_k      (bus.signal_K[i]),
      .i_load_d (bus.data_in[i]),
      .i_shl_d  (w_shl[i]),
      .i_rol_d  (w_rol[i]),
      .i_enable (bus.enable),
      .i_clear  (bus.clear_mask[i]),
      .i_preset (bus.preset_mask[i]),
      .i_mode   (bus.mode),
      .o_d      (w_next[i])
    );
  end

  always_ff @(posedge clock_pos) begin
    if (reset_pos) begin
      r_state   <= RESET_VALUE;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= w_diff;
    end
  end

  assign bus.signal_out     = r_state;
  assign bus.signal_out_neg = ~r_state;
  assign bus.serial_out     = r_state[WIDTH-1];
  assign bus.changed        = r_changed;

`ifdef JK_CHANGE_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clock_pos) begin
    if (reset_pos) begin
      r_count <= '0;
    end else if (w_diff && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.change_count = r_count;
`endif

endmodule : jk_register_bank

// File: tb/tb_jk_register_bank.sv
// Directed self-checking bench for jk_register_bank (WIDTH=8, RESET_VALUE=8'hA5).
module tb_jk_register_bank;
  import jk_bank_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_compared;
  int unsigned n_mismatched;

`ifdef JK_CHANGE_COUNT_EN
  jk_register_bank_if #(.WIDTH(8), .COUNT_WIDTH(4)) bus_if ();
`else
  jk_register_bank_if #(.WIDTH(8)) bus_if ();
`endif

  jk_register_bank #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .COUNT_WIDTH (4)
  ) dut (
    .clock_pos (clk),
    .reset_pos (rst),
    .bus       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.enable      = 1'b0;
    bus_if.mode        = MODE_JK;
    bus_if.signal_J    = '0;
    bus_if.signal_K    = '0;
    bus_if.data_in     = '0;
    bus_if.serial_in   = 1'b0;
    bus_if.clear_mask  = '0;
    bus_if.preset_mask = '0;
  endtask

  task automatic do_load(input logic [7:0] val);
    idle_inputs();
    bus_if.enable  = 1'b1;
    bus_if.mode    = MODE_LOAD;
    bus_if.data_in = val;
    step();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Reset held two cycles with busy inputs.
    rst                = 1'b1;
    bus_if.enable      = 1'b1;
    bus_if.mode        = MODE_LOAD;
    bus_if.signal_J    = 8'h3C;
    bus_if.signal_K    = 8'hC3;
    bus_if.data_in     = 8'h77;
    bus_if.serial_in   = 1'b1;
    bus_if.clear_mask  = 8'h11;
    bus_if.preset_mask = 8'h22;
    step();
    step();
    check("rst_out", bus_if.signal_out, 8'hA5);
    check("rst_neg", bus_if.signal_out_neg, 8'h5A);
    check("rst_changed", bus_if.changed, 0);
    check("rst_serout", bus_if.serial_out, 1);
`ifdef JK_CHANGE_COUNT_EN
    check("rst_count", bus_if.change_count, 0);
`endif

    // Clear all bits with enable low.
    rst = 1'b0;
    idle_inputs();
    bus_if.clear_mask = 8'hFF;
    step();
    check("clr_out", bus_if.signal_out, 8'h00);
    check("clr_changed", bus_if.changed, 1);

    // JK mode.
    idle_inputs();
    bus_if.enable   = 1'b1;
    bus_if.signal_J = 8'hF0;
    bus_if.signal_K = 8'h0F;
    step();
    check("jk_set", bus_if.signal_out, 8'hF0);
    check("jk_set_chg", bus_if.changed, 1);
    bus_if.signal_J = 8'hFF;
    bus_if.signal_K = 8'hFF;
    step();
    check("jk_tog", bus_if.signal_out, 8'h0F);
    check("jk_tog_chg", bus_if.changed, 1);
    check("jk_tog_neg", bus_if.signal_out_neg, 8'hF0);
    bus_if.signal_J = 8'h00;
    bus_if.signal_K = 8'h00;
    step();
    check("jk_hold", bus_if.signal_out, 8'h0F);
    check("jk_hold_chg", bus_if.changed, 0);

    // Masks over LOAD: clear beats preset on bit0.
    idle_inputs();
    bus_if.enable      = 1'b1;
    bus_if.mode        = MODE_LOAD;
    bus_if.data_in     = 8'hFF;
    bus_if.clear_mask  = 8'h01;
    bus_if.preset_mask = 8'h81;
    step();
    check("mask_out", bus_if.signal_out, 8'hFE);
    check("mask_chg", bus_if.changed, 1);

    // Shift and rotate.
    do_load(8'h81);
    check("load81", bus_if.signal_out, 8'h81);
    check("pre_shl_serout", bus_if.serial_out, 1);
    bus_if.mode      = MODE_SHL;
    bus_if.serial_in = 1'b0;
    step();
    check("shl_out", bus_if.signal_out, 8'h02);
    check("shl_serout", bus_if.serial_out, 0);
    check("shl_chg", bus_if.changed, 1);
    bus_if.mode = MODE_ROL;
    for (int i = 0; i < 7; i++) step();
    check("rol7_out", bus_if.signal_out, 8'h01);
    check("rol7_chg", bus_if.changed, 1);

    // Rotate boundaries.
    do_load(8'h00);
    bus_if.mode = MODE_ROL;
    step();
    check("rol_zero", bus_if.signal_out, 8'h00);
    check("rol_zero_chg", bus_if.changed, 0);
    do_load(8'hFF);
    check("load_ff_chg", bus_if.changed, 1);
    bus_if.mode = MODE_ROL;
    step();
    check("rol_ones", bus_if.signal_out, 8'hFF);
    check("rol_ones_chg", bus_if.changed, 0);

    // Preset on an already-set bit.
    idle_inputs();
    bus_if.preset_mask = 8'h01;
    step();
    check("preset_set", bus_if.signal_out, 8'hFF);
    check("preset_set_chg", bus_if.changed, 0);

    // Enable low, masks clear: hold for five cycles.
    idle_inputs();
    bus_if.mode    = MODE_LOAD;
    bus_if.data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("dis_hold", bus_if.signal_out, 8'hFF);
      check("dis_chg", bus_if.changed, 0);
    end

    // Masks still act with enable low.
    bus_if.clear_mask = 8'h0F;
    step();
    check("dis_mask", bus_if.signal_out, 8'hF0);
    check("dis_mask_chg", bus_if.changed, 1);

    // Shift in a one, then reset mid-shift.
    idle_inputs();
    bus_if.enable    = 1'b1;
    bus_if.mode      = MODE_SHL;
    bus_if.serial_in = 1'b1;
    step();
    check("shl_in1", bus_if.signal_out, 8'hE1);
    rst = 1'b1;
    step();
    check("rst_shl_out", bus_if.signal_out, 8'hA5);
    check("rst_shl_chg", bus_if.changed, 0);
    rst = 1'b0;

    // Long rotate of a single one (saturates the 4-bit counter when present).
    do_load(8'h01);
    bus_if.mode = MODE_ROL;
    for (int i = 0; i < 20; i++) step();
    check("rol20_out", bus_if.signal_out, 8'h10);
    check("rol20_chg", bus_if.changed, 1);
`ifdef JK_CHANGE_COUNT_EN
    check("count_sat", bus_if.change_count, 4'hF);
    rst = 1'b1;
    step();
    check("count_rst", bus_if.change_count, 0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_jk_register_bank
